// File: rtl/ucie_flit68_crc_checker.sv
// RX CRC-32 / length check stage for 68B flits, folding CHUNK_BITS payload bits per cycle.
// Optional macro UCIE_CRC_ERR_CNT_EN adds a saturating CRC error counter on crc_err_count.
package ucie_pkg;

  typedef struct packed {
    logic [15:0]  header;
    logic [15:0]  length;
    logic [479:0] payload;
    logic [31:0]  crc;
  } flit_68b_t;

  typedef struct packed {
    logic [7:0]  error_type;
    logic [7:0]  severity;
    logic [15:0] error_code;
    logic [31:0] error_data;
    logic [31:0] timestamp;
    logic [7:0]  source_id;
  } ucie_error_info_t;

  localparam logic [7:0]  ERR_CRC    = 8'h01;
  localparam logic [7:0]  ERR_FORMAT = 8'h03;
  localparam logic [31:0] CRC_POLY   = 32'h04C1_1DB7;

  // Bit-serial CRC-32, payload consumed from bit 0 upward, no reflection or final xor.
  function automatic logic [31:0] calc_crc32(input logic [479:0] data, input logic [31:0] init);
    logic [31:0] c;
    c = init;
    for (int i = 0; i < 480; i++) begin
      c = {c[30:0], 1'b0} ^ ((c[31] ^ data[i]) ? CRC_POLY : 32'h0);
    end
    return c;
  endfunction

endpackage

module ucie_flit68_crc_checker
  import ucie_pkg::*;
#(
  parameter int          CHUNK_BITS = 32,
  parameter logic [31:0] CRC_INIT   = 32'hFFFF_FFFF,
  parameter logic [15:0] MAX_LEN    = 16'd60,
  parameter logic [7:0]  SOURCE_ID  = 8'h10
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [$bits(flit_68b_t)-1:0]     in_flit,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [$bits(flit_68b_t)-1:0]     out_flit,
  output logic                             out_crc_ok,
  output logic                             out_len_ok,
  output logic [31:0]                      crc_calc,
  output logic                             err_valid,
  output logic [$bits(ucie_error_info_t)-1:0] err_info,
  output logic [15:0]                      crc_err_count
);

  localparam int NCH = 480 / CHUNK_BITS;
  localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
  // valid never drops and its payload never changes until that transfer.
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state, state_nxt;
  flit_68b_t        flit_q;
  flit_68b_t        in_f;
  logic [31:0]      crc_q;
  logic [31:0]      crc_fold;
  logic [KW-1:0]    k_q;
  logic [31:0]      ts_q;
  logic             crc_ok_q, len_ok_q, err_v_q;
  ucie_error_info_t err_q;
  logic [CHUNK_BITS-1:0] chunk;
  logic             last_chunk;
  logic             crc_ok_nxt, len_ok_nxt;

  assign in_f       = flit_68b_t'(in_flit);
  assign chunk      = flit_q.payload[k_q*CHUNK_BITS +: CHUNK_BITS];
  assign last_chunk = (k_q == KW'(NCH - 1));
  assign crc_ok_nxt = (crc_fold == flit_q.crc);
  assign len_ok_nxt = (flit_q.length <= MAX_LEN);

  always_comb begin
    crc_fold = crc_q;
    for (int i = 0; i < CHUNK_BITS; i++) begin
      crc_fold = {crc_fold[30:0], 1'b0} ^ ((crc_fold[31] ^ chunk[i]) ? CRC_POLY : 32'h0);
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = CALC;
      end
      CALC: begin
        if (last_chunk) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      flit_q   <= '0;
      crc_q    <= '0;
      k_q      <= '0;
      ts_q     <= '0;
      crc_ok_q <= 1'b0;
      len_ok_q <= 1'b0;
      err_v_q  <= 1'b0;
      err_q    <= '0;
    end else begin
      state   <= state_nxt;
      ts_q    <= ts_q + 32'd1;
      err_v_q <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            flit_q   <= in_f;
            crc_q    <= CRC_INIT;
            k_q      <= '0;
            crc_ok_q <= 1'b0;
            len_ok_q <= 1'b0;
          end
        end
        CALC: begin
          crc_q <= crc_fold;
          k_q   <= k_q + 1'b1;
          if (last_chunk) begin
            crc_ok_q <= crc_ok_nxt;
            len_ok_q <= len_ok_nxt;
            // Record is built on the entry edge so it is valid in the first DONE cycle.
            if (!crc_ok_nxt || !len_ok_nxt) begin
              err_v_q            <= 1'b1;
              err_q.timestamp    <= ts_q + 32'd1;
              err_q.source_id    <= SOURCE_ID;
              if (!len_ok_nxt) begin
                err_q.error_type <= ERR_FORMAT;
                err_q.severity   <= 8'h01;
                err_q.error_code <= 16'h0003;
                err_q.error_data <= {16'h0000, flit_q.length};
              end else begin
                err_q.error_type <= ERR_CRC;
                err_q.severity   <= 8'h02;
                err_q.error_code <= 16'h0001;
                err_q.error_data <= crc_fold;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign out_flit   = flit_q;
  assign out_crc_ok = crc_ok_q;
  assign out_len_ok = len_ok_q;
  assign crc_calc   = crc_q;
  assign err_valid  = err_v_q;
  assign err_info   = err_q;

`ifdef UCIE_CRC_ERR_CNT_EN
  logic [15:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (err_v_q && !crc_ok_q && (cnt_q != 16'hFFFF)) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign crc_err_count = cnt_q;
`else
  assign crc_err_count = 16'h0000;
`endif

endmodule

// File: doc/ucie_flit68_crc_checker.md
Name: ucie_flit68_crc_checker

Overview:
- Receive-side check stage for 68B flits (`flit_68b_t` from `ucie_pkg`), placed between the RX flit deframer and the protocol-layer demux.
- Computes CRC-32 over the 480-bit payload, CHUNK_BITS per cycle. The CRC matches `ucie_pkg::calc_crc32` semantics.
- Compares the result against the flit's `crc` field and validates the `length` field.
- Forwards the flit with a pass/fail verdict and emits a `ucie_error_info_t` record on failure.

Parameters:
- CHUNK_BITS, 32, payload bits folded into the CRC per cycle; must divide 480 (legal values: 8, 16, 32, 48, 60, 96, 120, 160, 240, 480).
- CRC_INIT, 32'hFFFF_FFFF, CRC seed loaded at flit accept.
- MAX_LEN, 16'd60, largest legal `length` field value, in bytes.
- SOURCE_ID, 8'h10, value driven on `err_info.source_id`.

Ports:
- clk  in  1  single clock; reset is synchronous and active-high
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input flit valid
- in_ready  out  1  block can accept a flit
- in_flit  in  $bits(flit_68b_t)  input flit
- out_valid  out  1  checked flit available
- out_ready  in  1  downstream accepts the flit
- out_flit  out  $bits(flit_68b_t)  captured flit, unmodified
- out_crc_ok  out  1  computed CRC equals `out_flit.crc`
- out_len_ok  out  1  `out_flit.length` <= MAX_LEN
- crc_calc  out  32  computed CRC
- err_valid  out  1  one-cycle error-record strobe
- err_info  out  $bits(ucie_error_info_t)  error record
- crc_err_count  out  16  CRC error count (optional feature)

Behaviour:
- Reset: state=IDLE; in_ready=1; out_valid=0; err_valid=0; out_flit=0; out_crc_ok=0; out_len_ok=0; crc_calc=0; err_info=0; timestamp counter=0; crc_err_count=0.
  - Reset asserted mid-CALC or mid-DONE aborts the flit. No output and no error record are produced for it.
- Timestamp: free-running 32-bit counter, +1 every cycle, wraps 32'hFFFF_FFFF -> 0.
- FSM:
  - IDLE: in_ready=1.
    - in_valid && in_ready: capture flit, crc<=CRC_INIT, chunk index k<=0, go to CALC.
  - CALC: in_ready=0.
    - Each cycle fold payload bits [k*CHUNK_BITS +: CHUNK_BITS] in ascending bit index i.
    - Per bit: fb = crc[31]^d[i]; crc = (crc<<1) ^ (fb ? 32'h04C11DB7 : 0).
    - After chunk NCH-1 (NCH = 480/CHUNK_BITS), go to DONE.
  - DONE: out_valid=1. out_flit, crc_calc, out_crc_ok and out_len_ok are stable until handshake.
    - out_valid && out_ready: go to IDLE.
- Latency: accept on edge N; chunk k folded on edge N+1+k; out_valid first high after edge N+NCH. With CHUNK_BITS=32 this is 15 cycles after accept.
- Throughput: one flit per NCH+2 cycles with out_ready held high. No overlap: in_ready stays 0 from accept until the DONE handshake.
- out_valid does not drop without handshake. Outputs hold under out_ready=0 indefinitely.
- Error record: err_valid pulses for exactly one cycle, the first DONE cycle, only if out_crc_ok=0 or out_len_ok=0.
  - Length failure (takes precedence when both fail): error_type=ERR_FORMAT (8'h03), severity=8'h01, error_code=16'h0003, error_data={16'h0000, length}.
  - CRC failure only: error_type=ERR_CRC (8'h01), severity=8'h02, error_code=16'h0001, error_data=crc_calc.
  - timestamp = counter value in the first DONE cycle; source_id = SOURCE_ID.
  - err_info holds its value until the next error record.
- in_valid while in_ready=0 is ignored; the upstream stage holds the flit.

Optional Feature:
- Macro: UCIE_CRC_ERR_CNT_EN.
- Defined: crc_err_count increments by 1 on each err_valid strobe where out_crc_ok=0 (length-only failures are not counted). It saturates at 16'hFFFF and clears only on rst.
- Undefined: no counter logic; crc_err_count is tied to 16'h0000. The port list is identical in both builds.

Test Plan:
- CRC_INIT=0, payload=0, crc=0, length=60, out_ready=1 -> out_valid 15 cycles after accept; crc_calc=0; out_crc_ok=1; out_len_ok=1; err_valid never asserts.
- Same flit with crc=32'h1 -> out_crc_ok=0; err_valid for 1 cycle; error_type=8'h01; error_data=0; crc_err_count=1 (macro on) or 0 (macro off).
- Random payload, default CRC_INIT, crc field from the golden `calc_crc32`-equivalent bench model -> out_crc_ok=1. Repeat for CHUNK_BITS=8, 32 and 480; crc_calc is identical and latency is 60, 15 and 1 cycles respectively.
- length=61 with bad crc -> error_type=8'h03; error_data=32'h0000_003D; out_crc_ok=0; counter still increments (macro on).
- out_ready=0 for 20 cycles in DONE, with in_valid held high -> outputs stable; in_ready=0; err_valid pulses once; second flit accepted only after the handshake.
- rst asserted on the 5th CALC cycle -> next cycle in_ready=1, out_valid=0, err_valid=0; a following flit is checked correctly.
